// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bus: button/switch levels in, strobes and status out.
// LAP_EN adds lap_btn and lap_hold.
interface stopwatch_ctrl_if;
  logic       en;
  logic       start_btn;
  logic       stop_btn;
  logic       softrst_sw;
  logic       inc_min_btn;
  logic       inc_sec_btn;
  logic       inc_sw;
  logic       sec_tick;
  logic       clr_time;
  logic       inc_min;
  logic       inc_sec;
  logic       running;
  logic [1:0] state;
`ifdef LAP_EN
  logic       lap_btn;
  logic       lap_hold;

  modport master (
    output en, start_btn, stop_btn, softrst_sw,
    output inc_min_btn, inc_sec_btn, inc_sw, lap_btn,
    input  sec_tick, clr_time, inc_min, inc_sec,
    input  running, state, lap_hold
  );

  modport slave (
    input  en, start_btn, stop_btn, softrst_sw,
    input  inc_min_btn, inc_sec_btn, inc_sw, lap_btn,
    output sec_tick, clr_time, inc_min, inc_sec,
    output running, state, lap_hold
  );
`else
  modport master (
    output en, start_btn, stop_btn, softrst_sw,
    output inc_min_btn, inc_sec_btn, inc_sw,
    input  sec_tick, clr_time, inc_min, inc_sec,
    input  running, state
  );

  modport slave (
    input  en, start_btn, stop_btn, softrst_sw,
    input  inc_min_btn, inc_sec_btn, inc_sw,
    output sec_tick, clr_time, inc_min, inc_sec,
    output running, state
  );
`endif
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: run/pause/idle, 1 Hz tick, inc auto-repeat.
// Optional macro LAP_EN adds the lap_hold display-freeze toggle.
module stopwatch_ctrl #(
  parameter int TICK_DIV      = 25000000,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);

  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PER  = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] R_ONE  = RW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  state_t        r_state;
  logic          r_start_q;
  logic          r_stop_q;
  logic          r_incm_q;
  logic          r_incs_q;
  logic [PW-1:0] r_presc;
  logic [RW-1:0] r_rep_m;
  logic [RW-1:0] r_rep_s;
  logic          r_ph_m;
  logic          r_ph_s;
  logic          r_sec_tick;
  logic          r_clr_time;
  logic          r_inc_min;
  logic          r_inc_sec;
  logic          r_running;

  state_t        w_state_nx;
  logic [PW-1:0] w_presc_nx;
  logic [RW-1:0] w_rep_m_nx;
  logic [RW-1:0] w_rep_s_nx;
  logic          w_ph_m_nx;
  logic          w_ph_s_nx;
  logic          w_tick_nx;
  logic          w_incm_nx;
  logic          w_incs_nx;

  logic          w_start_e;
  logic          w_stop_e;
  logic          w_incm_e;
  logic          w_incs_e;
  logic          w_incm_fall;
  logic          w_inc_ok;
  logic          w_sec_fresh;
  logic [RW-1:0] w_lim_m;
  logic [RW-1:0] w_lim_s;

  assign w_start_e   = bus.start_btn & ~r_start_q;
  assign w_stop_e    = bus.stop_btn & ~r_stop_q;
  assign w_incm_e    = bus.inc_min_btn & ~r_incm_q;
  assign w_incs_e    = bus.inc_sec_btn & ~r_incs_q;
  assign w_incm_fall = r_incm_q & ~bus.inc_min_btn;
  assign w_sec_fresh = w_incs_e | w_incm_fall;
  assign w_inc_ok    = bus.inc_sw & ~bus.softrst_sw &
                       (r_state != S_RUN);
  assign w_lim_m     = r_ph_m ? R_PER : R_DLY;
  assign w_lim_s     = r_ph_s ? R_PER : R_DLY;

  // Next state, prescaler, repeat counters and strobes.
  always_comb begin
    w_state_nx = r_state;
    w_presc_nx = r_presc;
    w_rep_m_nx = r_rep_m;
    w_rep_s_nx = r_rep_s;
    w_ph_m_nx  = r_ph_m;
    w_ph_s_nx  = r_ph_s;
    w_tick_nx  = 1'b0;
    w_incm_nx  = 1'b0;
    w_incs_nx  = 1'b0;
    if (bus.en) begin
      if (bus.softrst_sw) begin
        w_state_nx = S_IDLE;
        w_presc_nx = '0;
        w_rep_m_nx = '0;
        w_rep_s_nx = '0;
        w_ph_m_nx  = 1'b0;
        w_ph_s_nx  = 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE:
            if (w_start_e & ~w_stop_e) w_state_nx = S_RUN;
          S_RUN:
            if (w_stop_e) w_state_nx = S_PAUSE;
          S_PAUSE:
            if (w_start_e & ~w_stop_e) w_state_nx = S_RUN;
          default:
            w_state_nx = S_IDLE;
        endcase

        if (r_state == S_RUN) begin
          if (r_presc == P_LAST) begin
            w_presc_nx = '0;
            w_tick_nx  = 1'b1;
          end else begin
            w_presc_nx = r_presc + P_ONE;
          end
        end else if (r_state == S_IDLE) begin
          w_presc_nx = '0;
        end

        // Count of 0 means not armed; a held button only
        // repeats after a strobe from a fresh press.
        if (w_inc_ok & bus.inc_min_btn) begin
          if (w_incm_e) begin
            w_incm_nx  = 1'b1;
            w_rep_m_nx = R_ONE;
            w_ph_m_nx  = 1'b0;
          end else if (r_rep_m != '0) begin
            if (r_rep_m == w_lim_m) begin
              w_incm_nx  = 1'b1;
              w_rep_m_nx = R_ONE;
              w_ph_m_nx  = 1'b1;
            end else begin
              w_rep_m_nx = r_rep_m + R_ONE;
            end
          end
        end else begin
          w_rep_m_nx = '0;
          w_ph_m_nx  = 1'b0;
        end

        // inc_min owns the strobe while held; its release
        // counts as a fresh inc_sec press.
        if (w_inc_ok & bus.inc_sec_btn & ~bus.inc_min_btn) begin
          if (w_sec_fresh) begin
            w_incs_nx  = 1'b1;
            w_rep_s_nx = R_ONE;
            w_ph_s_nx  = 1'b0;
          end else if (r_rep_s != '0) begin
            if (r_rep_s == w_lim_s) begin
              w_incs_nx  = 1'b1;
              w_rep_s_nx = R_ONE;
              w_ph_s_nx  = 1'b1;
            end else begin
              w_rep_s_nx = r_rep_s + R_ONE;
            end
          end
        end else begin
          w_rep_s_nx = '0;
          w_ph_s_nx  = 1'b0;
        end
      end
    end
  end

  // Edge-detect history, updated even while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_q <= 1'b0;
      r_stop_q  <= 1'b0;
      r_incm_q  <= 1'b0;
      r_incs_q  <= 1'b0;
    end else begin
      r_start_q <= bus.start_btn;
      r_stop_q  <= bus.stop_btn;
      r_incm_q  <= bus.inc_min_btn;
      r_incs_q  <= bus.inc_sec_btn;
    end
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_running  <= 1'b0;
      r_clr_time <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_running  <= (w_state_nx == S_RUN);
      r_clr_time <= bus.softrst_sw;
    end
  end

  // Prescaler, repeat counters and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc    <= '0;
      r_rep_m    <= '0;
      r_rep_s    <= '0;
      r_ph_m     <= 1'b0;
      r_ph_s     <= 1'b0;
      r_sec_tick <= 1'b0;
      r_inc_min  <= 1'b0;
      r_inc_sec  <= 1'b0;
    end else begin
      r_presc    <= w_presc_nx;
      r_rep_m    <= w_rep_m_nx;
      r_rep_s    <= w_rep_s_nx;
      r_ph_m     <= w_ph_m_nx;
      r_ph_s     <= w_ph_s_nx;
      r_sec_tick <= w_tick_nx;
      r_inc_min  <= w_incm_nx;
      r_inc_sec  <= w_incs_nx;
    end
  end

  assign bus.sec_tick = r_sec_tick;
  assign bus.clr_time = r_clr_time;
  assign bus.inc_min  = r_inc_min;
  assign bus.inc_sec  = r_inc_sec;
  assign bus.running  = r_running;
  assign bus.state    = r_state;

`ifdef LAP_EN
  logic r_lap_q;
  logic r_lap_hold;
  logic w_lap_nx;

  // Lap toggles only while running; idle or soft reset clears it.
  always_comb begin
    w_lap_nx = r_lap_hold;
    if (bus.en) begin
      if (bus.softrst_sw | (w_state_nx == S_IDLE)) begin
        w_lap_nx = 1'b0;
      end else if ((r_state == S_RUN) &
                   bus.lap_btn & ~r_lap_q) begin
        w_lap_nx = ~r_lap_hold;
      end
    end
  end

  // Lap edge history and hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lap_q    <= 1'b0;
      r_lap_hold <= 1'b0;
    end else begin
      r_lap_q    <= bus.lap_btn;
      r_lap_hold <= w_lap_nx;
    end
  end

  assign bus.lap_hold = r_lap_hold;
`endif

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM that sequences the stopwatch time-counter datapath from debounced button and switch levels. Sits between the debouncers and the min/sec counter plus seven-segment mux in top. Generates the 1 Hz count tick, clear and increment strobes, and run status. Includes auto-repeat for held increment buttons.

Parameters:
TICK_DIV, 25000000, clk cycles per sec_tick (25 MHz -> 1 Hz); min 2
REPEAT_DELAY, 12500000, cycles an inc button must stay held before the first auto-repeat strobe
REPEAT_PERIOD, 5000000, cycles between auto-repeat strobes after the first

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  global enable; low freezes all counters and FSM
start_btn  in  1  debounced level; rising edge = start
stop_btn  in  1  debounced level; rising edge = stop
softrst_sw  in  1  level; high = clear time and hold in IDLE
inc_min_btn  in  1  debounced level; minute increment
inc_sec_btn  in  1  debounced level; second increment
inc_sw  in  1  level; 1 = increment buttons enabled
sec_tick  out  1  one-cycle count strobe to time counter
clr_time  out  1  clear strobe/level to time counter
inc_min  out  1  one-cycle minute increment strobe
inc_sec  out  1  one-cycle second increment strobe
running  out  1  1 in RUNNING
state  out  2  IDLE=00, RUNNING=01, PAUSED=10

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset: state=IDLE, running=0, sec_tick=0, inc_min=0, inc_sec=0, clr_time=1 for exactly the first cycle after rst deasserts, then 0. Prescaler, repeat counters and edge-detect registers are cleared; edge registers reset to 0.
- Edge detect: edge = btn & ~btn_q. btn_q updates every cycle, including when en=0, so presses made while en=0 are lost.
- en=0: FSM, prescaler and repeat counters hold. All strobes are 0. clr_time still follows softrst_sw.
- FSM, evaluated when en=1. Priority: softrst_sw > stop edge > start edge.
  - softrst_sw=1: next state IDLE; prescaler cleared; clr_time=1 every cycle it is high.
  - IDLE: start edge -> RUNNING. Stop edge -> no change.
  - RUNNING: stop edge -> PAUSED. Start edge is ignored.
  - PAUSED: start edge -> RUNNING. Stop edge -> no change.
  - Simultaneous start and stop edges: stop wins; RUNNING -> PAUSED, otherwise no change.
- Latency: the state, running and clr_time outputs change on the same clock edge that samples the first high level of the button or switch. The new value is visible one cycle after the input rises.
- Prescaler: 0..TICK_DIV-1, advances only in RUNNING with en=1.
  - At TICK_DIV-1 it wraps to 0, and sec_tick=1 in the following cycle.
  - First tick comes TICK_DIV cycles after entering RUNNING from IDLE.
  - PAUSED keeps the partial count, so a resume continues the fraction. IDLE and softrst clear it.
- Increment: active only when inc_sw=1 and state is IDLE or PAUSED, with softrst_sw=0.
  - Rising edge -> one strobe (inc_min or inc_sec) the next cycle.
  - Held continuously: another strobe after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
  - Release, inc_sw=0, or entering RUNNING clears that button's repeat counter and stops strobes.
  - Both buttons held: inc_min has priority. The inc_sec repeat counter is held at 0 and no inc_sec strobes are issued until inc_min_btn drops; inc_sec then behaves as a fresh press.
- Wrap and carry of minutes/seconds belong to the time counter, not this block.

Optional Feature:
LAP_EN
- Defined: adds input lap_btn (1) and output lap_hold (1, reset 0).
  - In RUNNING, a lap_btn rising edge toggles lap_hold. lap_hold=1 tells the display to freeze while counting continues.
  - lap_hold clears on entering IDLE or on softrst_sw. It keeps its value through PAUSED.
  - Lap edges in IDLE or PAUSED are ignored.
- Not defined: neither port exists, and there is no lap logic.

Test Plan:
All scenarios use TICK_DIV=10, REPEAT_DELAY=20, REPEAT_PERIOD=5.
- Reset then idle 5 cycles -> clr_time=1 for exactly 1 cycle after rst drops; state=00; no strobes.
- start_btn high 1 cycle -> state=01 next cycle; sec_tick pulses at 10, 20, 30 cycles after the start edge; stop_btn edge at cycle 25 -> state=10 with prescaler=5; start again -> next tick 5 cycles later.
- start_btn and stop_btn rise in the same cycle while RUNNING -> state=10; same from IDLE -> state=00.
- inc_sw=1, hold inc_sec_btn 35 cycles in IDLE -> inc_sec strobes at cycles 1, 21, 26, 31 only; with inc_sw=0 -> none.
- Hold inc_min_btn and inc_sec_btn together for 10 cycles, release inc_min -> only inc_min strobes while both are held; one inc_sec strobe the cycle after inc_min releases.
- softrst_sw high 4 cycles while RUNNING -> clr_time=1 for those 4 cycles, state=00, no sec_tick; en=0 during RUNNING for 7 cycles -> tick delayed exactly 7 cycles.
